// File: rtl/pix_tx_pkg.sv
// Shared definitions for the pixel UART transmitter.
// Holds the serializer state encoding, the sequencer state encoding, the
// 8N1 frame constants, the pixel field positions and the YUV->RGB helper.
package pix_tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic {SEQ_IDLE, SEQ_BYTE1} seq_state_t;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Pixel field positions: {Y, Ur, Vr} on input, {R, G, B} on output.
  localparam int unsigned Y_MSB = 11;
  localparam int unsigned Y_LSB = 8;
  localparam int unsigned U_MSB = 7;
  localparam int unsigned U_LSB = 4;
  localparam int unsigned V_MSB = 3;
  localparam int unsigned V_LSB = 0;

  function automatic logic [3:0] clamp4(input logic signed [6:0] x);
    if (x < 7'sd0)       return 4'h0;
    else if (x > 7'sd15) return 4'hF;
    else                 return x[3:0];
  endfunction

  // G = Y - ((Ur+Vr) >>> 2); R = Ur + G; B = Vr + G; all on unclamped G,
  // clamped to 0..15 only at the end. 7 bits covers the -16..26 range.
  function automatic logic [11:0] yuv_to_rgb(input logic [11:0] pix);
    logic signed [6:0] y, u, v, s, g, r, b;
    y = signed'({3'b000, pix[Y_MSB:Y_LSB]});
    u = signed'({{3{pix[U_MSB]}}, pix[U_MSB:U_LSB]});
    v = signed'({{3{pix[V_MSB]}}, pix[V_MSB:V_LSB]});
    s = (u + v) >>> 2;
    g = y - s;
    r = u + g;
    b = v + g;
    return {clamp4(r), clamp4(g), clamp4(b)};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a one-byte holding buffer.
// Ports: clk, rst (async, active high), data/load (byte to send; a load while
// busy is held and sent back-to-back after the current stop bit), tx (serial
// line, idle high, registered), done (one-cycle pulse after each stop bit).
module uart_tx_byte
  import pix_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       done
);

  localparam int unsigned   BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    hold;
  logic          pending;
  logic          bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      hold    <= '0;
      pending <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) baud <= bit_end ? '0 : baud + 1'b1;
      if (load && state != IDLE) begin
        hold    <= data;
        pending <= 1'b1;
      end
      unique case (state)
        IDLE: if (load) begin
          shreg <= data;
          tx    <= START_BIT;
          state <= START;
        end
        START: if (bit_end) begin
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            tx    <= STOP_BIT;
            state <= STOP;
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: if (bit_end) begin
          done <= 1'b1;
          // A byte loaded on this very edge counts as pending, so the next
          // start bit follows the stop bit with no idle cycle.
          if (pending || load) begin
            shreg   <= pending ? hold : data;
            pending <= 1'b0;
            tx      <= START_BIT;
            state   <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pix_uart_tx.sv
// Pixel FIFO + YUV->RGB conversion + two-byte sequencer feeding uart_tx_byte.
// Ports: clk, rst (async, active high), pix_in/pix_valid (pixel push, accepted
// while pix_ready), conv_en (convert at pop when 1), pix_ready (FIFO not full),
// tx (UART line, idle high), busy (frame on line or FIFO non-empty),
// overflow (sticky: push attempted while not ready).
module pix_uart_tx
  import pix_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pix_in,
  input  logic        pix_valid,
  input  logic        conv_en,
  output logic        pix_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  seq_state_t    seq;
  logic          load;
  logic [7:0]    byte_data;
  logic [3:0]    b_q;
  logic          done;
  logic [1:0]    inflight, inflight_next;
  logic          space;
  logic [11:0]   rgb;

  always_comb begin
    push          = pix_valid && pix_ready;
    // Bytes held by the serializer (active + buffered). Counting the load and
    // done pulses of this cycle keeps the estimate conservative.
    inflight_next = inflight + {1'b0, load} - {1'b0, done};
    space         = (inflight_next < 2'd2);
    pop           = (seq == SEQ_IDLE) && (count != '0) && space;
    count_next    = count + CW'(push) - CW'(pop);
    rgb           = conv_en ? yuv_to_rgb(mem[rd_ptr]) : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_ready <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      inflight  <= '0;
      seq       <= SEQ_IDLE;
      load      <= 1'b0;
      byte_data <= '0;
      b_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      pix_ready <= (count_next != CW'(FIFO_DEPTH));
      overflow  <= overflow | (pix_valid & ~pix_ready);
      inflight  <= inflight_next;
      busy      <= (count_next != '0) || (inflight_next != '0) || pop || (seq != SEQ_IDLE);
      load      <= 1'b0;
      unique case (seq)
        SEQ_IDLE: if (pop) begin
          byte_data <= rgb[11:4];
          b_q       <= rgb[3:0];
          load      <= 1'b1;
          seq       <= SEQ_BYTE1;
        end
        SEQ_BYTE1: if (space) begin
          byte_data <= {b_q, 4'b0000};
          load      <= 1'b1;
          seq       <= SEQ_IDLE;
        end
        default: seq <= SEQ_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk  (clk),
    .rst  (rst),
    .data (byte_data),
    .load (load),
    .tx   (tx),
    .done (done)
  );

endmodule

// File: tb/tb_pix_uart_tx.sv
module tb_pix_uart_tx;

  logic        clk = 1'b0;
  logic        rst, rst_d;
  logic [11:0] pix_in, pix_in_d;
  logic        pix_valid, pix_valid_d, conv_en, conv_en_d;
  logic        pix_ready, tx, busy, overflow;
  logic        pix_ready_d, tx_d, busy_d, overflow_d;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pix_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .conv_en(conv_en),
    .pix_ready(pix_ready), .tx(tx), .busy(busy), .overflow(overflow)
  );

  pix_uart_tx dut_d (
    .clk(clk), .rst(rst_d), .pix_in(pix_in_d), .pix_valid(pix_valid_d), .conv_en(conv_en_d),
    .pix_ready(pix_ready_d), .tx(tx_d), .busy(busy_d), .overflow(overflow_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel != 0) ? tx_d : tx;
  endfunction

  // Receive one 8N1 frame sampling every cycle at the falling clock edge.
  // gap = idle cycles before the start bit (== tmo on timeout); good = every
  // bit held exactly cpb cycles, start 0, stop 1.
  task automatic rx_frame(input int sel, input int cpb, input int tmo,
                          output logic [7:0] b, output int gap, output logic good);
    logic v, cur;
    gap  = 0;
    good = 1'b1;
    b    = 'x;
    v    = 1'b0;
    while (line(sel) !== 1'b0 && gap < tmo) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= tmo) begin
      good = 1'b0;
      return;
    end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < cpb; c++) begin
        cur = line(sel);
        if (c == 0) v = cur;
        else if (cur !== v) good = 1'b0;
        if (k == 0 && cur !== 1'b0) good = 1'b0;
        if (k == 9 && cur !== 1'b1) good = 1'b0;
        if (c == 0 && k >= 1 && k <= 8) b[k-1] = cur;
        @(negedge clk);
      end
    end
  endtask

  task automatic push(input logic [11:0] p);
    pix_in    = p;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  logic [7:0]  rb;
  int          gp;
  logic        ok;
  logic [11:0] pv [8];
  logic [7:0]  got [10];
  int          gaps [10];
  logic        goods [10];
  int          w;

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    pix_in = '0; pix_valid = 1'b0; conv_en = 1'b0;
    pix_in_d = '0; pix_valid_d = 1'b0; conv_en_d = 1'b0;
    pv = '{12'h10A, 12'h21B, 12'h32C, 12'h43D, 12'h54E, 12'h65F, 12'h760, 12'h871};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    rst = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(pix_ready), 32'd1);

    // Pass-through: A5C -> A5, C0
    push(12'hA5C);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("pt_b0", 32'(rb), 32'hA5);
    check("pt_b0_frame", 32'(ok), 32'd1);
    check("pt_busy_mid", 32'(busy), 32'd1);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("pt_b1", 32'(rb), 32'hC0);
    check("pt_b1_frame", 32'(ok), 32'd1);
    check("pt_b1_gap", 32'(gp), 32'd0);
    repeat (2) @(negedge clk);
    check("pt_busy_end", 32'(busy), 32'd0);
    check("pt_tx_idle", 32'(tx), 32'd1);

    // Conversion
    conv_en = 1'b1;
    push(12'h82E);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("cv1_b0", 32'(rb), 32'hA8);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("cv1_b1", 32'(rb), 32'h60);
    push(12'h077);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("cv2_b0", 32'(rb), 32'h40);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("cv2_b1", 32'(rb), 32'h40);
    conv_en = 1'b0;
    repeat (5) @(negedge clk);

    // Two pixels back-to-back -> four contiguous frames
    pix_in = 12'h123; pix_valid = 1'b1;
    @(negedge clk);
    pix_in = 12'h456;
    @(negedge clk);
    pix_valid = 1'b0;
    rx_frame(0, 4, 20, rb, gp, ok);
    check("b2b_0", 32'(rb), 32'h12);
    check("b2b_0_frame", 32'(ok), 32'd1);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("b2b_1", 32'(rb), 32'h30);
    check("b2b_1_gap_ok", 32'(gp <= 2), 32'd1);
    check("b2b_1_frame", 32'(ok), 32'd1);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("b2b_2", 32'(rb), 32'h45);
    check("b2b_2_gap_ok", 32'(gp <= 2), 32'd1);
    check("b2b_2_frame", 32'(ok), 32'd1);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("b2b_3", 32'(rb), 32'h60);
    check("b2b_3_gap_ok", 32'(gp <= 2), 32'd1);
    check("b2b_3_frame", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);

    // Overflow burst: 8 pushes into an idle 4-deep FIFO
    check("ovf_before", 32'(overflow), 32'd0);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          pix_in = pv[i];
          pix_valid = 1'b1;
          @(negedge clk);
        end
        pix_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_full", 32'(pix_ready), 32'd0);
      end
      begin
        for (int j = 0; j < 10; j++) begin
          rx_frame(0, 4, 40, got[j], gaps[j], goods[j]);
        end
      end
    join
    for (int j = 0; j < 10; j++) begin
      check($sformatf("ovf_byte%0d", j), 32'(got[j]),
            (j % 2 == 0) ? 32'(pv[j/2][11:4]) : 32'({pv[j/2][3:0], 4'h0}));
      check($sformatf("ovf_frame%0d", j), 32'(goods[j] && (j == 0 || gaps[j] <= 2)), 32'd1);
    end
    rx_frame(0, 4, 200, rb, gp, ok);
    check("ovf_no_extra", 32'(gp), 32'd200);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of byte0 DATA with 3 pixels queued
    pix_in = 12'h003; pix_valid = 1'b1;
    @(negedge clk);
    pix_in = 12'h004;
    @(negedge clk);
    pix_in = 12'h005;
    @(negedge clk);
    pix_valid = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("mr_start_seen", 32'(w < 50), 32'd1);
    repeat (10) @(negedge clk);
    check("mr_tx_low", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mr_tx_high", 32'(tx), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    check("mr_ready", 32'(pix_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_frame(0, 4, 200, rb, gp, ok);
    check("mr_silent", 32'(gp), 32'd200);
    check("mr_idle_busy", 32'(busy), 32'd0);
    check("mr_idle_ready", 32'(pix_ready), 32'd1);
    push(12'hABC);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("mr_new_b0", 32'(rb), 32'hAB);
    rx_frame(0, 4, 20, rb, gp, ok);
    check("mr_new_b1", 32'(rb), 32'hC0);

    // Default parameters: 868 clk per bit
    pix_in_d = 12'h5A3; pix_valid_d = 1'b1;
    @(negedge clk);
    pix_valid_d = 1'b0;
    rx_frame(1, 868, 20, rb, gp, ok);
    check("def_b0", 32'(rb), 32'h5A);
    check("def_b0_frame", 32'(ok), 32'd1);
    rx_frame(1, 868, 20, rb, gp, ok);
    check("def_b1", 32'(rb), 32'h30);
    check("def_b1_frame", 32'(ok), 32'd1);
    check("def_tx_idle", 32'(tx_d), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
